// File: rtl/fib_stream_if.sv
// Output stream of fib_stream: one term per beat, tagged with its index, last flag and overflow flag.
interface fib_stream_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] index;
    logic             last;
    logic             ovf;

    modport master (output valid, data, index, last, ovf, input ready);
    modport slave  (input valid, data, index, last, ovf, output ready);
endinterface

// File: rtl/fib_stream.sv
// Two-seed additive recurrence generator. Emits n terms as a valid/ready stream and tags
// every term whose true value has wrapped.
module fib_stream #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] n_i,
    input  logic [WIDTH-1:0] seed0_i,
    input  logic [WIDTH-1:0] seed1_i,
    fib_stream_if.master     out_if,
    output logic             busy_o,
    output logic             done_o,
    output logic             overflow_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             a_ov_q, a_ov_d, b_ov_q, b_ov_d;
    logic [CNT_W-1:0] idx_q, idx_d, n_q, n_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum;
    logic             last;

    // The extra top bit of the sum is the carry that feeds wrap tracking.
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign last = (state_q == StRun) && (idx_q == n_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        a_ov_d  = a_ov_q;
        b_ov_d  = b_ov_q;
        idx_d   = idx_q;
        n_d     = n_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    n_d     = n_i;
                    a_d     = seed0_i;
                    b_d     = seed1_i;
                    a_ov_d  = 1'b0;
                    b_ov_d  = 1'b0;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (n_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (abort_i) begin
                    state_d = StIdle;
                    ovf_d   = 1'b0;
                end else if (out_if.ready) begin
                    a_d    = b_q;
                    b_d    = sum[WIDTH-1:0];
                    a_ov_d = b_ov_q;
                    b_ov_d = a_ov_q | b_ov_q | sum[WIDTH];
                    idx_d  = idx_q + CNT_W'(1);
                    ovf_d  = ovf_q | a_ov_q;
                    if (last) state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            a_ov_q  <= 1'b0;
            b_ov_q  <= 1'b0;
            idx_q   <= '0;
            n_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_ov_q  <= a_ov_d;
            b_ov_q  <= b_ov_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_if.valid = (state_q == StRun);
    assign out_if.data  = a_q;
    assign out_if.index = idx_q;
    assign out_if.last  = last;
    assign out_if.ovf   = a_ov_q;
    assign busy_o       = (state_q == StRun);
    assign done_o       = (state_q == StDone);
    assign overflow_o   = ovf_q;

endmodule
